nonce_collector: RTL and testbench

- Sits directly downstream of an array of CORES miner instances.
- Captures every nonce_found pulse together with its nonce_out value, arbitrates between cores, and buffers the results in a FIFO.
- Presents results to the host/UART bridge over a valid/ready interface.
- Counts results lost to back-pressure, and flushes all state when new work is loaded.

---
 rtl/nonce_collector_if.sv | 10 +
 rtl/nonce_collector.sv | 124 ++++++++++++
 tb/tb_nonce_collector.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/nonce_collector_if.sv
// rtl/nonce_collector_if.sv - result stream from the nonce collector to the host bridge
interface nonce_collector_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_nonce;
    logic [3:0]  out_core;

    modport master (output out_valid, output out_nonce, output out_core, input out_ready);
    modport slave  (input out_valid, input out_nonce, input out_core, output out_ready);
endinterface

// File: rtl/nonce_collector.sv
// rtl/nonce_collector.sv - per-core hold registers, round-robin arbiter and result FIFO
module nonce_collector #(
    parameter int CORES = 4,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [CORES-1:0]      found,
    input  logic [32*CORES-1:0]   nonce_in,
    nonce_collector_if.master     res,
    output logic [AW:0]           fifo_level,
    output logic [15:0]           drop_count
);

    logic [CORES-1:0] hold_full;
    logic [31:0]      hold_nonce [CORES];
    logic [3:0]       rr_ptr;

    logic [35:0]      mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push;

    logic             grant_any;
    logic [3:0]       grant_idx;
    logic [31:0]      grant_nonce;
    logic [CORES-1:0] grant_sel;
    logic [CORES-1:0] granted;
    logic [4:0]       cand;

    logic [CORES-1:0] drop_vec;
    logic [4:0]       drop_sum;
    logic [16:0]      drop_total;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && res.out_ready;
    assign fifo_level = wr_ptr - rd_ptr;

    // Head is gated so the bus reads zero while empty, independent of stale storage.
    assign res.out_valid = !fifo_empty;
    assign res.out_nonce = fifo_empty ? 32'd0 : mem[rd_ptr[AW-1:0]][31:0];
    assign res.out_core  = fifo_empty ? 4'd0  : mem[rd_ptr[AW-1:0]][35:32];

    // Rotating priority search beginning at rr_ptr; first full hold wins.
    always_comb begin
        grant_any   = 1'b0;
        grant_idx   = 4'd0;
        grant_nonce = 32'd0;
        grant_sel   = '0;
        cand        = 5'd0;
        for (int k = 0; k < CORES; k++) begin
            cand = {1'b0, rr_ptr} + 5'(k);
            if (cand >= 5'(CORES))
                cand = cand - 5'(CORES);
            for (int j = 0; j < CORES; j++) begin
                if (!grant_any && cand == 5'(j) && hold_full[j]) begin
                    grant_any    = 1'b1;
                    grant_idx    = 4'(j);
                    grant_nonce  = hold_nonce[j];
                    grant_sel[j] = 1'b1;
                end
            end
        end
    end

    assign push    = grant_any && (!fifo_full || pop);
    assign granted = push ? grant_sel : '0;

    always_comb begin
        drop_sum = 5'd0;
        for (int i = 0; i < CORES; i++) begin
            drop_vec[i] = found[i] && hold_full[i] && !granted[i];
            drop_sum    = drop_sum + 5'(drop_vec[i]);
        end
        drop_total = {1'b0, drop_count} + 17'(drop_sum);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_full  <= '0;
            rr_ptr     <= 4'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= 16'd0;
            for (int i = 0; i < CORES; i++)
                hold_nonce[i] <= 32'd0;
        end else if (clear) begin
            hold_full  <= '0;
            rr_ptr     <= 4'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= 16'd0;
        end else begin
            for (int i = 0; i < CORES; i++) begin
                if (found[i] && (!hold_full[i] || granted[i])) begin
                    hold_full[i]  <= 1'b1;
                    hold_nonce[i] <= nonce_in[32*i +: 32];
                end else if (granted[i]) begin
                    hold_full[i] <= 1'b0;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant_idx == 4'(CORES-1)) ? 4'd0 : grant_idx + 4'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            drop_count <= drop_total[16] ? 16'hFFFF : drop_total[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {grant_idx, grant_nonce};
    end

endmodule

// File: tb/tb_nonce_collector.sv
// tb/tb_nonce_collector.sv - directed self-checking bench for nonce_collector
module tb_nonce_collector;
    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic [3:0]   found;
    logic [127:0] nonce_in;
    logic [4:0]   fifo_level;
    logic [15:0]  drop_count;
    int           checks = 0;
    int           failures = 0;

    nonce_collector_if nif ();

    nonce_collector #(.CORES(4), .DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .found      (found),
        .nonce_in   (nonce_in),
        .res        (nif),
        .fifo_level (fifo_level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  exp_core  [5];
    logic [31:0] exp_nonce [5];

    initial begin
        reset = 1'b0; clear = 1'b0; found = 4'b0; nonce_in = '0; nif.out_ready = 1'b0;
        #2;
        check("rst_valid", 32'(nif.out_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_drop",  32'(drop_count), 32'd0);
        check("rst_nonce", nif.out_nonce, 32'd0);
        tick();
        reset = 1'b1;

        // Single result: two-edge latency, then popped.
        nif.out_ready = 1'b1;
        found = 4'b0001; nonce_in[31:0] = 32'h1234ABCD;
        tick();
        found = 4'b0;
        check("single_e0_valid", 32'(nif.out_valid), 32'd0);
        tick();
        check("single_e1_valid", 32'(nif.out_valid), 32'd1);
        check("single_nonce",    nif.out_nonce, 32'h1234ABCD);
        check("single_core",     32'(nif.out_core), 32'd0);
        tick();
        check("single_popped",   32'(nif.out_valid), 32'd0);
        check("single_level",    32'(fifo_level), 32'd0);

        // Clear returns the round-robin pointer to core 0.
        clear = 1'b1; tick(); clear = 1'b0;

        // All cores at once.
        nif.out_ready = 1'b0;
        found = 4'b1111;
        for (int i = 0; i < 4; i++) nonce_in[32*i +: 32] = 32'hA0 + 32'(i);
        tick();
        found = 4'b0;
        repeat (4) tick();
        check("simul_level", 32'(fifo_level), 32'd4);
        check("simul_drop",  32'(drop_count), 32'd0);
        nif.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("simul_core%0d", k),  32'(nif.out_core), 32'(k));
            check($sformatf("simul_nonce%0d", k), nif.out_nonce, 32'hA0 + 32'(k));
            tick();
        end
        check("simul_empty", 32'(nif.out_valid), 32'd0);

        // Round robin: grant core 2, then 0101 -> core 0 first, then 1001 -> core 3 first.
        nif.out_ready = 1'b0;
        found = 4'b0100; nonce_in[95:64] = 32'hB2;
        tick(); found = 4'b0; tick();
        found = 4'b0101; nonce_in[31:0] = 32'hC0; nonce_in[95:64] = 32'hC2;
        tick(); found = 4'b0; tick(); tick();
        found = 4'b1001; nonce_in[31:0] = 32'hD0; nonce_in[127:96] = 32'hD3;
        tick(); found = 4'b0; tick(); tick();
        check("rr_level", 32'(fifo_level), 32'd5);
        exp_core[0] = 4'd2; exp_nonce[0] = 32'hB2;
        exp_core[1] = 4'd0; exp_nonce[1] = 32'hC0;
        exp_core[2] = 4'd2; exp_nonce[2] = 32'hC2;
        exp_core[3] = 4'd3; exp_nonce[3] = 32'hD3;
        exp_core[4] = 4'd0; exp_nonce[4] = 32'hD0;
        nif.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_core%0d", k),  32'(nif.out_core), 32'(exp_core[k]));
            check($sformatf("rr_nonce%0d", k), nif.out_nonce, exp_nonce[k]);
            tick();
        end
        check("rr_empty", 32'(nif.out_valid), 32'd0);

        // Back-pressure: 20 pulses on core 0, 16 in FIFO, 1 in hold, 3 dropped.
        nif.out_ready = 1'b0;
        for (int p = 0; p < 20; p++) begin
            found = 4'b0001; nonce_in[31:0] = 32'h100 + 32'(p);
            tick();
            found = 4'b0;
            tick();
        end
        check("bp_level", 32'(fifo_level), 32'd16);
        check("bp_drop",  32'(drop_count), 32'd3);
        check("bp_head",  nif.out_nonce, 32'h100);
        nif.out_ready = 1'b1;
        tick();
        check("full_pushpop_level", 32'(fifo_level), 32'd16);
        for (int k = 1; k < 17; k++) begin
            check($sformatf("drain_nonce%0d", k), nif.out_nonce, 32'h100 + 32'(k));
            tick();
        end
        check("drain_empty", 32'(nif.out_valid), 32'd0);

        // Drop counter saturation: all cores firing every cycle into a full FIFO.
        nif.out_ready = 1'b0;
        found = 4'b1111;
        repeat (16500) tick();
        found = 4'b0;
        check("sat_drop",  32'(drop_count), 32'hFFFF);
        check("sat_level", 32'(fifo_level), 32'd16);

        // Clear with a found pulse on the same edge: pulse lost, everything empty.
        clear = 1'b1; found = 4'b0010; nonce_in[63:32] = 32'hEE;
        tick();
        clear = 1'b0; found = 4'b0;
        check("clr_valid", 32'(nif.out_valid), 32'd0);
        check("clr_level", 32'(fifo_level), 32'd0);
        check("clr_drop",  32'(drop_count), 32'd0);
        tick(); tick();
        check("clr_pulse_lost", 32'(nif.out_valid), 32'd0);

        // Asynchronous reset between edges.
        found = 4'b0001; nonce_in[31:0] = 32'h55;
        tick(); found = 4'b0; tick();
        check("pre_rst_valid", 32'(nif.out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(nif.out_valid), 32'd0);
        check("arst_nonce", nif.out_nonce, 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_valid", 32'(nif.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
